// File: rtl/control_bus.sv
// control_bus
//   Main control unit for a single-issue RV32I-subset core (lw, sw, R-type,
//   I-type ALU, beq, jal). Opcode, funct3, funct7[5] and the ALU Zero flag
//   are decoded combinationally. The resulting control word is registered,
//   so every output lags its inputs by one clock.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears every output
//   funct7_5       instruction bit 30
//   funct3_2_0     instruction bits 14:12
//   OP6_0          opcode, instruction bits 6:0
//   Zero           ALU zero flag, used for beq
//   PCSrc          1 = branch/jump target, 0 = PC+4
//   ResultSrc1_0   00 ALU, 01 memory read data, 10 PC+4
//   MemWrite       data memory write enable
//   ALUSrc         0 = register B, 1 = immediate
//   ImmSrc1_0      00 I, 01 S, 10 B, 11 J
//   RegWrite       register file write enable
//   ALUControl2_0  000 add, 001 sub, 010 and, 011 or, 101 slt
module control_bus (
    input  logic       clk,
    input  logic       reset,
    input  logic       funct7_5,
    input  logic [2:0] funct3_2_0,
    input  logic [6:0] OP6_0,
    input  logic       Zero,
    output logic       PCSrc,
    output logic [1:0] ResultSrc1_0,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc1_0,
    output logic       RegWrite,
    output logic [2:0] ALUControl2_0
);

    typedef struct packed {
        logic       pc_src;
        logic [1:0] result_src;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] imm_src;
        logic       reg_write;
        logic [2:0] alu_control;
    } ctrl_t;

    // Main decoder outputs
    logic       reg_write_d;
    logic [1:0] imm_src_d;
    logic       alu_src_d;
    logic       mem_write_d;
    logic [1:0] result_src_d;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic [2:0] alu_control_d;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Unknown opcodes fall through to all-zero: a no-op with no writes.
    always_comb begin
        reg_write_d  = 1'b0;
        imm_src_d    = 2'b00;
        alu_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        result_src_d = 2'b00;
        branch       = 1'b0;
        jump         = 1'b0;
        alu_op       = 2'b00;
        case (OP6_0)
            7'b0000011: begin // lw
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
            end
            7'b0100011: begin // sw
                imm_src_d    = 2'b01;
                alu_src_d    = 1'b1;
                mem_write_d  = 1'b1;
            end
            7'b0110011: begin // R-type
                reg_write_d  = 1'b1;
                alu_op       = 2'b10;
            end
            7'b0010011: begin // I-type ALU
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                alu_op       = 2'b10;
            end
            7'b1100011: begin // beq
                imm_src_d    = 2'b10;
                branch       = 1'b1;
                alu_op       = 2'b01;
            end
            7'b1101111: begin // jal
                reg_write_d  = 1'b1;
                imm_src_d    = 2'b11;
                result_src_d = 2'b10;
                jump         = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder. Subtract on funct3=000 needs both opcode bit 5 (R-type)
    // and funct7[5]; for addi, bit 30 is immediate data and must not subtract.
    always_comb begin
        alu_control_d = 3'b000;
        case (alu_op)
            2'b01: alu_control_d = 3'b001;
            2'b10: begin
                case (funct3_2_0)
                    3'b000:  alu_control_d = (OP6_0[5] & funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control_d = 3'b101;
                    3'b110:  alu_control_d = 3'b011;
                    3'b111:  alu_control_d = 3'b010;
                    default: alu_control_d = 3'b000;
                endcase
            end
            default: alu_control_d = 3'b000;
        endcase
    end

    always_comb begin
        ctrl_d             = '0;
        ctrl_d.pc_src      = (branch & Zero) | jump;
        ctrl_d.result_src  = result_src_d;
        ctrl_d.mem_write   = mem_write_d;
        ctrl_d.alu_src     = alu_src_d;
        ctrl_d.imm_src     = imm_src_d;
        ctrl_d.reg_write   = reg_write_d;
        ctrl_d.alu_control = alu_control_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ctrl_q <= '0;
        else       ctrl_q <= ctrl_d;
    end

    assign PCSrc         = ctrl_q.pc_src;
    assign ResultSrc1_0  = ctrl_q.result_src;
    assign MemWrite      = ctrl_q.mem_write;
    assign ALUSrc        = ctrl_q.alu_src;
    assign ImmSrc1_0     = ctrl_q.imm_src;
    assign RegWrite      = ctrl_q.reg_write;
    assign ALUControl2_0 = ctrl_q.alu_control;

endmodule

// File: tb/tb_control_bus.sv
// Bench for control_bus: directed vectors push their expected control word
// into a scoreboard queue; a monitor pops and compares one entry after each
// rising edge while entries are pending.
module tb_control_bus;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       funct7_5 = 1'b0;
    logic [2:0] funct3_2_0 = 3'b000;
    logic [6:0] OP6_0 = 7'b0110011;
    logic       Zero = 1'b0;
    logic       PCSrc;
    logic [1:0] ResultSrc1_0;
    logic       MemWrite;
    logic       ALUSrc;
    logic [1:0] ImmSrc1_0;
    logic       RegWrite;
    logic [2:0] ALUControl2_0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic        z;
        logic [10:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[$];

    control_bus dut (
        .clk           (clk),
        .reset         (reset),
        .funct7_5      (funct7_5),
        .funct3_2_0    (funct3_2_0),
        .OP6_0         (OP6_0),
        .Zero          (Zero),
        .PCSrc         (PCSrc),
        .ResultSrc1_0  (ResultSrc1_0),
        .MemWrite      (MemWrite),
        .ALUSrc        (ALUSrc),
        .ImmSrc1_0     (ImmSrc1_0),
        .RegWrite      (RegWrite),
        .ALUControl2_0 (ALUControl2_0)
    );

    always #5 clk = ~clk;

    // Packed as {PCSrc, ResultSrc, MemWrite, ALUSrc, ImmSrc, RegWrite, ALUControl}
    function automatic logic [10:0] mk(input logic pc, input logic [1:0] res,
                                       input logic mw, input logic as,
                                       input logic [1:0] imm, input logic rw,
                                       input logic [2:0] alu);
        return {pc, res, mw, as, imm, rw, alu};
    endfunction

    function automatic logic [10:0] outs();
        return {PCSrc, ResultSrc1_0, MemWrite, ALUSrc, ImmSrc1_0, RegWrite, ALUControl2_0};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (pc res mw as imm rw alu)", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input logic z, input logic [10:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.f3 = f3; v.f75 = f75; v.z = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Monitor: one scoreboard entry per rising edge while entries are pending.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            check(e.name, e.exp);
        end
    end

    initial begin
        sb_t e;
        logic [10:0] last_exp;

        //        name        opcode       f3      f75   Z     pc res    mw   as   imm    rw   alu
        add_vec("r_sub",    7'b0110011, 3'b000, 1'b1, 1'b0, mk(0, 2'b00, 0, 0, 2'b00, 1, 3'b001));
        add_vec("r_slt",    7'b0110011, 3'b010, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 2'b00, 1, 3'b101));
        add_vec("r_or",     7'b0110011, 3'b110, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 2'b00, 1, 3'b011));
        add_vec("r_and",    7'b0110011, 3'b111, 1'b1, 1'b0, mk(0, 2'b00, 0, 0, 2'b00, 1, 3'b010));
        add_vec("r_sll",    7'b0110011, 3'b001, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 2'b00, 1, 3'b000));
        add_vec("r_zero1",  7'b0110011, 3'b000, 1'b0, 1'b1, mk(0, 2'b00, 0, 0, 2'b00, 1, 3'b000));
        add_vec("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, mk(0, 2'b01, 0, 1, 2'b00, 1, 3'b000));
        add_vec("sw",       7'b0100011, 3'b010, 1'b0, 1'b0, mk(0, 2'b00, 1, 1, 2'b01, 0, 3'b000));
        add_vec("beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, mk(1, 2'b00, 0, 0, 2'b10, 0, 3'b001));
        add_vec("beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, mk(0, 2'b00, 0, 0, 2'b10, 0, 3'b001));
        add_vec("beq_f7",   7'b1100011, 3'b111, 1'b1, 1'b1, mk(1, 2'b00, 0, 0, 2'b10, 0, 3'b001));
        add_vec("jal_z0",   7'b1101111, 3'b000, 1'b0, 1'b0, mk(1, 2'b10, 0, 0, 2'b11, 1, 3'b000));
        add_vec("jal_z1",   7'b1101111, 3'b110, 1'b1, 1'b1, mk(1, 2'b10, 0, 0, 2'b11, 1, 3'b000));
        add_vec("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, mk(0, 2'b00, 0, 1, 2'b00, 1, 3'b000));
        add_vec("ori",      7'b0010011, 3'b110, 1'b0, 1'b0, mk(0, 2'b00, 0, 1, 2'b00, 1, 3'b011));
        add_vec("slti",     7'b0010011, 3'b010, 1'b0, 1'b0, mk(0, 2'b00, 0, 1, 2'b00, 1, 3'b101));
        add_vec("andi",     7'b0010011, 3'b111, 1'b0, 1'b0, mk(0, 2'b00, 0, 1, 2'b00, 1, 3'b010));
        add_vec("illegal",  7'b1111111, 3'b000, 1'b1, 1'b1, mk(0, 2'b00, 0, 0, 2'b00, 0, 3'b000));
        add_vec("illegal2", 7'b0000000, 3'b111, 1'b0, 1'b1, mk(0, 2'b00, 0, 0, 2'b00, 0, 3'b000));
        add_vec("lw_after", 7'b0000011, 3'b000, 1'b1, 1'b1, mk(0, 2'b01, 0, 1, 2'b00, 1, 3'b000));

        // R-type add is on the inputs from time 0 and is captured at the first
        // edge, so the flops hold a non-zero word before reset is tested.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_async", 11'd0);
        @(posedge clk);
        #2;
        check("reset_held", 11'd0);

        // Release mid-cycle: still zero until the next rising edge loads R-add.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_release", 11'd0);
        e.name = "r_add_after_reset";
        e.exp  = mk(0, 2'b00, 0, 0, 2'b00, 1, 3'b000);
        sb.push_back(e);
        last_exp = e.exp;

        foreach (vecs[i]) begin
            @(negedge clk);
            OP6_0      = vecs[i].op;
            funct3_2_0 = vecs[i].f3;
            funct7_5   = vecs[i].f75;
            Zero       = vecs[i].z;
            e.name = vecs[i].name;
            e.exp  = vecs[i].exp;
            sb.push_back(e);
            last_exp = e.exp;
        end

        // Inputs changed just after the edge must not reach the outputs
        // until the following edge.
        @(posedge clk);
        #3;
        OP6_0      = 7'b1101111;
        funct3_2_0 = 3'b000;
        funct7_5   = 1'b0;
        Zero       = 1'b0;
        e.name = "jal_late_change";
        e.exp  = mk(1, 2'b10, 0, 0, 2'b11, 1, 3'b000);
        sb.push_back(e);
        #1;
        check("hold_between_edges", last_exp);

        // Bounded drain of the scoreboard.
        for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
